// File: rtl/top_key_tx.sv
// Source end of the 9-bit key stream: a small FIFO feeding a registered
// valid/accept output, with an optional idle gap after each accepted word.
module top_key_tx #(
    parameter int depth_p = 4,
    parameter int gap_p   = 0
) (
    input  logic                           main_clk_i,
    input  logic                           main_rst_i,
    input  logic                           wr_en_i,
    input  logic [8:0]                     wr_data_i,
    output logic                           wr_full_o,
    output logic                           ovf_o,
    input  logic                           ovf_clr_i,
    output logic [$clog2(depth_p+2)-1:0]   level_o,
    output logic                           key_valid_o,
    input  logic                           key_accept_i,
    output logic [8:0]                     key_data_o
);

    // Handshake: a word moves when key_valid_o && key_accept_i at a rising edge;
    // once raised, key_valid_o and key_data_o hold until that transfer.

    localparam int ptr_w = $clog2(depth_p);
    localparam int cnt_w = $clog2(depth_p + 1);
    localparam int lvl_w = $clog2(depth_p + 2);
    localparam int gap_w = (gap_p < 2) ? 1 : $clog2(gap_p + 1);

    localparam logic [cnt_w-1:0] depth_c = cnt_w'(depth_p);
    localparam logic [gap_w-1:0] gap_c   = gap_w'(gap_p);
    localparam logic [gap_w-1:0] gap_one = gap_w'(1);

    localparam logic [1:0] st_idle = 2'd0;
    localparam logic [1:0] st_send = 2'd1;
    localparam logic [1:0] st_gap  = 2'd2;

    logic [8:0]       mem_q [depth_p];
    logic [ptr_w-1:0] wr_ptr_q, wr_ptr_d;
    logic [ptr_w-1:0] rd_ptr_q, rd_ptr_d;
    logic [cnt_w-1:0] count_q, count_d;
    logic [1:0]       state_q, state_d;
    logic [gap_w-1:0] gap_cnt_q, gap_cnt_d;
    logic             valid_q, valid_d;
    logic [8:0]       data_q, data_d;
    logic             ovf_q, ovf_d;
    logic             full_q, full_d;
    logic [lvl_w-1:0] level_q, level_d;

    logic xfer;
    logic full_now;
    logic push_ok;
    logic pop;

    always_comb begin
        xfer      = valid_q & key_accept_i;
        full_now  = (count_q == depth_c);
        push_ok   = wr_en_i & ~full_now;
        pop       = 1'b0;
        state_d   = state_q;
        valid_d   = valid_q;
        gap_cnt_d = gap_cnt_q;

        case (state_q)
            st_idle: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    valid_d = 1'b1;
                    state_d = st_send;
                end
            end
            st_send: begin
                if (xfer) begin
                    if (gap_p == 0) begin
                        if (count_q != '0) begin
                            pop = 1'b1;
                        end else begin
                            valid_d = 1'b0;
                            state_d = st_idle;
                        end
                    end else begin
                        valid_d   = 1'b0;
                        gap_cnt_d = gap_c;
                        state_d   = st_gap;
                    end
                end
            end
            st_gap: begin
                gap_cnt_d = gap_cnt_q - gap_one;
                // The last gap edge already applies the idle rule, so valid stays low for exactly gap_p cycles.
                if (gap_cnt_q == gap_one) begin
                    if (count_q != '0) begin
                        pop     = 1'b1;
                        valid_d = 1'b1;
                        state_d = st_send;
                    end else begin
                        state_d = st_idle;
                    end
                end
            end
            default: begin
                state_d = st_idle;
            end
        endcase

        data_d   = pop ? mem_q[rd_ptr_q] : data_q;
        rd_ptr_d = rd_ptr_q + ptr_w'(pop);
        wr_ptr_d = wr_ptr_q + ptr_w'(push_ok);
        count_d  = count_q + cnt_w'(push_ok) - cnt_w'(pop);
        full_d   = (count_d == depth_c);
        level_d  = lvl_w'(count_d) + lvl_w'(valid_d);

        // A dropped push outranks a same-edge clear.
        if (wr_en_i && full_now) begin
            ovf_d = 1'b1;
        end else if (ovf_clr_i) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    always_ff @(posedge main_clk_i) begin
        if (!main_rst_i && push_ok) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    always_ff @(posedge main_clk_i) begin
        if (main_rst_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            state_q   <= st_idle;
            gap_cnt_q <= '0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            ovf_q     <= 1'b0;
            full_q    <= 1'b0;
            level_q   <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            state_q   <= state_d;
            gap_cnt_q <= gap_cnt_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            ovf_q     <= ovf_d;
            full_q    <= full_d;
            level_q   <= level_d;
        end
    end

    assign wr_full_o   = full_q;
    assign ovf_o       = ovf_q;
    assign level_o     = level_q;
    assign key_valid_o = valid_q;
    assign key_data_o  = data_q;

endmodule

// File: tb/tb_top_key_tx.sv
// Bench for top_key_tx: two instances (gap 0 and gap 2) share one stimulus and
// are compared against a word-queue reference model and an order scoreboard.
module tb_top_key_tx;

    localparam int depth = 4;
    localparam int lw    = $clog2(depth + 2);

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [8:0]    wr_data;
    logic          ovf_clr;
    logic          accept;

    logic          full0, ovf0, valid0;
    logic [lw-1:0] level0;
    logic [8:0]    data0;
    logic          full2, ovf2, valid2;
    logic [lw-1:0] level2;
    logic [8:0]    data2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    top_key_tx #(.depth_p(depth), .gap_p(0)) u_gap0 (
        .main_clk_i(clk), .main_rst_i(rst),
        .wr_en_i(wr_en), .wr_data_i(wr_data),
        .wr_full_o(full0), .ovf_o(ovf0), .ovf_clr_i(ovf_clr),
        .level_o(level0),
        .key_valid_o(valid0), .key_accept_i(accept), .key_data_o(data0)
    );

    top_key_tx #(.depth_p(depth), .gap_p(2)) u_gap2 (
        .main_clk_i(clk), .main_rst_i(rst),
        .wr_en_i(wr_en), .wr_data_i(wr_data),
        .wr_full_o(full2), .ovf_o(ovf2), .ovf_clr_i(ovf_clr),
        .level_o(level2),
        .key_valid_o(valid2), .key_accept_i(accept), .key_data_o(data2)
    );

    // Reference model: index 0 models gap 0, index 1 models gap 2.
    int         m_gap [2] = '{0, 2};
    logic [8:0] m_buf [2][64];
    int         m_head [2];
    int         m_size [2];
    bit         m_valid [2];
    logic [8:0] m_data [2];
    int         m_idle [2];
    bit         m_ovf [2];

    logic [8:0] exp_q0[$];
    logic [8:0] exp_q1[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge(input int i);
        int  had;
        bit  xfer;
        bit  may_load;
        if (rst) begin
            m_head[i] = 0; m_size[i] = 0; m_valid[i] = 0; m_data[i] = '0;
            m_idle[i] = 0; m_ovf[i] = 0;
            if (i == 0) exp_q0.delete(); else exp_q1.delete();
            return;
        end
        had      = m_size[i];
        xfer     = m_valid[i] && accept;
        may_load = 0;
        if (m_valid[i]) begin
            if (xfer) begin
                m_valid[i] = 0;
                if (m_gap[i] == 0) may_load = 1;
                else m_idle[i] = m_gap[i];
            end
        end else begin
            // each low cycle uses up one required idle cycle; loading allowed once none remain
            if (m_idle[i] > 0) m_idle[i]--;
            if (m_idle[i] == 0) may_load = 1;
        end
        if (may_load && had > 0) begin
            m_data[i]  = m_buf[i][m_head[i]];
            m_head[i]  = (m_head[i] + 1) % 64;
            m_size[i]--;
            m_valid[i] = 1;
        end
        if (wr_en && had == depth) begin
            m_ovf[i] = 1;
        end else begin
            if (ovf_clr) m_ovf[i] = 0;
            if (wr_en) begin
                m_buf[i][(m_head[i] + m_size[i]) % 64] = wr_data;
                m_size[i]++;
                if (i == 0) exp_q0.push_back(wr_data); else exp_q1.push_back(wr_data);
            end
        end
    endtask

    task automatic tick();
        bit         x0, x2;
        logic [8:0] d0, d2;
        x0 = valid0 && accept && !rst;
        x2 = valid2 && accept && !rst;
        d0 = data0;
        d2 = data2;
        @(posedge clk);
        if (x0) begin
            if (exp_q0.size() == 0) check("sb0_spurious", 32'd1, 32'd0);
            else check("sb0_order", 32'(d0), 32'(exp_q0.pop_front()));
        end
        if (x2) begin
            if (exp_q1.size() == 0) check("sb2_spurious", 32'd1, 32'd0);
            else check("sb2_order", 32'(d2), 32'(exp_q1.pop_front()));
        end
        model_edge(0);
        model_edge(1);
        #1;
        check("g0_valid", 32'(valid0), 32'(m_valid[0]));
        check("g0_data",  32'(data0),  32'(m_data[0]));
        check("g0_level", 32'(level0), 32'(m_size[0] + int'(m_valid[0])));
        check("g0_full",  32'(full0),  32'(m_size[0] == depth));
        check("g0_ovf",   32'(ovf0),   32'(m_ovf[0]));
        check("g2_valid", 32'(valid2), 32'(m_valid[1]));
        check("g2_data",  32'(data2),  32'(m_data[1]));
        check("g2_level", 32'(level2), 32'(m_size[1] + int'(m_valid[1])));
        check("g2_full",  32'(full2),  32'(m_size[1] == depth));
        check("g2_ovf",   32'(ovf2),   32'(m_ovf[1]));
    endtask

    task automatic idle_ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        int         vcount;
        logic [6:0] pat;
        logic [8:0] w;

        rst = 1'b1; wr_en = 1'b0; wr_data = '0; ovf_clr = 1'b0; accept = 1'b0;
        idle_ticks(2);
        check("rst_valid", 32'(valid0 | valid2), 32'd0);
        check("rst_level", 32'(level0 | level2), 32'd0);
        rst = 1'b0;

        // single word, accept held high
        accept = 1'b1; wr_en = 1'b1; wr_data = 9'h1A5;
        tick();
        check("t1_level_e1", 32'(level0), 32'd1);
        wr_en = 1'b0;
        tick();
        check("t1_valid_e2", 32'(valid0), 32'd1);
        check("t1_data_e2",  32'(data0),  32'h1A5);
        check("t1_level_e2", 32'(level0), 32'd1);
        tick();
        check("t1_valid_e3", 32'(valid0), 32'd0);
        check("t1_level_e3", 32'(level0), 32'd0);
        idle_ticks(4);

        // back-to-back with gap 0
        vcount = 0;
        for (int k = 1; k <= 4; k++) begin
            wr_en = 1'b1; wr_data = 9'(k);
            tick();
            vcount += int'(valid0);
        end
        wr_en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            vcount += int'(valid0);
        end
        check("t2_valid_cycles", 32'(vcount), 32'd4);
        idle_ticks(10);

        // gap 2 pattern with three preloaded words
        accept = 1'b0;
        for (int k = 0; k < 3; k++) begin
            wr_en = 1'b1; wr_data = 9'($urandom_range(0, 511));
            tick();
        end
        wr_en = 1'b0; accept = 1'b1;
        pat = {6'd0, valid2};
        for (int k = 0; k < 6; k++) begin
            tick();
            pat = {pat[5:0], valid2};
        end
        check("t3_gap_pattern", 32'(pat), 32'b1001001);
        idle_ticks(8);

        // backpressure fills the FIFO
        accept = 1'b0;
        for (int k = 0; k < 10; k++) begin
            wr_en = (k < 5); wr_data = 9'($urandom_range(0, 511));
            tick();
        end
        check("t4_full",  32'({full0, full2}), 32'b11);
        check("t4_level0", 32'(level0), 32'(depth + 1));
        check("t4_level2", 32'(level2), 32'(depth + 1));

        // overflow: plain, sticky, with transfer, clear racing a set, clear alone
        wr_en = 1'b1; wr_data = 9'h055;
        tick();
        check("t5_ovf_set", 32'({ovf0, ovf2}), 32'b11);
        wr_en = 1'b0;
        tick();
        check("t5_ovf_sticky", 32'({ovf0, ovf2}), 32'b11);
        wr_en = 1'b1; accept = 1'b1; wr_data = 9'h0AA;
        tick();
        accept = 1'b0; wr_data = 9'h0BB;
        tick();
        ovf_clr = 1'b1; wr_data = 9'h0CC;
        tick();
        check("t5_clr_vs_set", 32'({ovf0, ovf2}), 32'b11);
        wr_en = 1'b0;
        tick();
        check("t5_clr_alone", 32'({ovf0, ovf2}), 32'b00);
        ovf_clr = 1'b0; accept = 1'b1;
        idle_ticks(24);

        // reset mid-handshake
        accept = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wr_en = 1'b1; wr_data = 9'($urandom_range(0, 511));
            tick();
        end
        wr_en = 1'b0; rst = 1'b1;
        tick();
        check("t6_valid",   32'({valid0, valid2}), 32'b00);
        check("t6_level",   32'(level0 | level2), 32'd0);
        check("t6_ovf_full", 32'({ovf0, ovf2, full0, full2}), 32'd0);
        rst = 1'b0;
        w = 9'h13C;
        wr_en = 1'b1; wr_data = w;
        tick();
        check("t6_valid_e1", 32'({valid0, valid2}), 32'b00);
        wr_en = 1'b0;
        tick();
        check("t6_valid_e2", 32'({valid0, valid2}), 32'b11);
        check("t6_data_e2",  32'(data2), 32'(w));
        accept = 1'b1;
        idle_ticks(4);

        // random traffic
        for (int k = 0; k < 3000; k++) begin
            rst     = ($urandom_range(0, 299) == 0);
            wr_en   = ($urandom_range(0, 99) < 45);
            wr_data = 9'($urandom_range(0, 511));
            accept  = ($urandom_range(0, 99) < 60);
            ovf_clr = ($urandom_range(0, 99) < 5);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
